// File: rtl/multi_tone_gen.sv
// rtl/multi_tone_gen.sv - multi-channel tone source (sine/square/saw/noise), saturating sum, Avalon-ST output
// Optional triangular dither before saturation: define MULTI_TONE_GEN_DITHER_EN.
module multi_tone_gen #(
  parameter int CHANNELS = 2,
  parameter int PHASE_W  = 32,
  parameter int OUT_W    = 16,
  parameter int LUT_AW   = 10,
  localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_wr,
  input  logic [CHAN_W-1:0]  cfg_chan,
  input  logic [PHASE_W-1:0] cfg_phase_inc,
  input  logic [8:0]         cfg_amp,
  input  logic [1:0]         cfg_mode,
  input  logic               cfg_en,
  input  logic               src_ready,
  output logic               src_valid,
  output logic [OUT_W-1:0]   src_data,
  output logic [1:0]         src_error
);
  localparam int LUT_N = 1 << LUT_AW;
  localparam int SUM_W = OUT_W + $clog2(CHANNELS) + 1;
  localparam logic signed [OUT_W-1:0] FS_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(FS_POS);
  localparam logic signed [SUM_W-1:0] SAT_LO = -SAT_HI - 1;
  localparam logic [LUT_AW:0] LUT_TOP = {1'b1, {LUT_AW{1'b0}}};

  function automatic logic [OUT_W-1:0] lut_val(input int k);
    real x;
    x = ((2.0 ** (OUT_W - 1)) - 1.0) * $sin(3.14159265358979323846 / 2.0 * k / LUT_N);
    return OUT_W'($rtoi(x + 0.5));
  endfunction

  function automatic logic signed [OUT_W-1:0] gain(input logic signed [OUT_W-1:0] w,
                                                   input logic [8:0] a);
    logic [OUT_W+9:0] prod;
    prod = {{10{w[OUT_W-1]}}, w} * {{(OUT_W+1){1'b0}}, a};
    return prod[OUT_W+7:8];
  endfunction

  // Quarter-wave table resolved at elaboration time
  logic [OUT_W-1:0] lut [LUT_N+1];
  for (genvar k = 0; k <= LUT_N; k++) begin : g_lut
    localparam logic [OUT_W-1:0] LV = lut_val(k);
    assign lut[k] = LV;
  end

  logic [PHASE_W-1:0] phase_q [CHANNELS], phase_d [CHANNELS];
  logic [PHASE_W-1:0] inc_q [CHANNELS], inc_d [CHANNELS];
  logic [8:0]         amp_q [CHANNELS], amp_d [CHANNELS];
  logic [1:0]         mode_q [CHANNELS], mode_d [CHANNELS];
  logic [CHANNELS-1:0] en_q, en_d;
  logic [15:0]        lfsr_q, lfsr_d;

  logic [PHASE_W-1:0] s1_phase_q [CHANNELS], s1_phase_d [CHANNELS];
  logic [8:0]         s1_amp_q [CHANNELS], s1_amp_d [CHANNELS];
  logic [1:0]         s1_mode_q [CHANNELS], s1_mode_d [CHANNELS];
  logic [CHANNELS-1:0] s1_en_q, s1_en_d;
  logic [15:0]        s1_lfsr_q, s1_lfsr_d;
  logic               s1_valid_q, s1_valid_d;

  logic signed [OUT_W-1:0] s2_wave_q [CHANNELS], s2_wave_d [CHANNELS];
  logic [8:0]         s2_amp_q [CHANNELS], s2_amp_d [CHANNELS];
  logic [CHANNELS-1:0] s2_en_q, s2_en_d;
  logic               s2_valid_q, s2_valid_d;

  logic signed [OUT_W-1:0] s3_scaled_q [CHANNELS], s3_scaled_d [CHANNELS];
  logic               s3_valid_q, s3_valid_d;

  logic               src_valid_q, src_valid_d;
  logic [OUT_W-1:0]   src_data_q, src_data_d;
  logic [1:0]         src_error_q, src_error_d;
  logic [OUT_W-1:0]   noise;
  logic               adv;

`ifdef MULTI_TONE_GEN_DITHER_EN
  logic [15:0] s2_lfsr_q, s2_lfsr_d, s3_lfsr_q, s3_lfsr_d;
  logic        s2_any_q, s2_any_d, s3_any_q, s3_any_d;
`endif

  assign adv = src_ready | ~src_valid_q;

  if (OUT_W <= 16) begin : g_noise_narrow
    assign noise = s1_lfsr_q[15 -: OUT_W];
  end else begin : g_noise_wide
    assign noise = {s1_lfsr_q, {(OUT_W-16){1'b0}}};
  end

  always_comb begin
    phase_d = phase_q;
    inc_d   = inc_q;
    amp_d   = amp_q;
    mode_d  = mode_q;
    en_d    = en_q;
    lfsr_d  = lfsr_q;
    if (adv) begin
      for (int c = 0; c < CHANNELS; c++) phase_d[c] = phase_q[c] + inc_q[c];
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    // A config write restarts the channel at phase 0 even on an advancing cycle
    if (cfg_wr && (int'(cfg_chan) < CHANNELS)) begin
      phase_d[cfg_chan] = '0;
      inc_d[cfg_chan]   = cfg_phase_inc;
      amp_d[cfg_chan]   = (cfg_amp > 9'd256) ? 9'd256 : cfg_amp;
      mode_d[cfg_chan]  = cfg_mode;
      en_d[cfg_chan]    = cfg_en;
    end
  end

  always_comb begin
    logic [1:0]           quad;
    logic [LUT_AW-1:0]    off;
    logic [LUT_AW:0]      idx;
    logic signed [SUM_W-1:0] acc;
    quad = '0;
    off  = '0;
    idx  = '0;
    acc  = '0;
    s1_phase_d = s1_phase_q;  s1_amp_d = s1_amp_q;  s1_mode_d = s1_mode_q;
    s1_en_d    = s1_en_q;     s1_lfsr_d = s1_lfsr_q; s1_valid_d = s1_valid_q;
    s2_wave_d  = s2_wave_q;   s2_amp_d = s2_amp_q;  s2_en_d = s2_en_q;  s2_valid_d = s2_valid_q;
    s3_scaled_d = s3_scaled_q; s3_valid_d = s3_valid_q;
    src_valid_d = src_valid_q; src_data_d = src_data_q; src_error_d = src_error_q;
`ifdef MULTI_TONE_GEN_DITHER_EN
    s2_lfsr_d = s2_lfsr_q; s3_lfsr_d = s3_lfsr_q; s2_any_d = s2_any_q; s3_any_d = s3_any_q;
`endif
    if (adv) begin
      s1_phase_d = phase_q;  s1_amp_d = amp_q;  s1_mode_d = mode_q;
      s1_en_d    = en_q;     s1_lfsr_d = lfsr_q; s1_valid_d = 1'b1;

      for (int c = 0; c < CHANNELS; c++) begin
        quad = s1_phase_q[c][PHASE_W-1 -: 2];
        off  = s1_phase_q[c][PHASE_W-3 -: LUT_AW];
        idx  = quad[0] ? (LUT_TOP - {1'b0, off}) : {1'b0, off};
        case (s1_mode_q[c])
          2'd0:    s2_wave_d[c] = quad[1] ? -lut[idx] : lut[idx];
          2'd1:    s2_wave_d[c] = s1_phase_q[c][PHASE_W-1] ? -FS_POS : FS_POS;
          2'd2:    s2_wave_d[c] = s1_phase_q[c][PHASE_W-1 -: OUT_W];
          default: s2_wave_d[c] = noise;
        endcase
      end
      s2_amp_d   = s1_amp_q;
      s2_en_d    = s1_en_q;
      s2_valid_d = s1_valid_q;

      for (int c = 0; c < CHANNELS; c++)
        s3_scaled_d[c] = s2_en_q[c] ? gain(s2_wave_q[c], s2_amp_q[c]) : '0;
      s3_valid_d = s2_valid_q;

      for (int c = 0; c < CHANNELS; c++) acc = acc + SUM_W'(s3_scaled_q[c]);
`ifdef MULTI_TONE_GEN_DITHER_EN
      s2_lfsr_d = s1_lfsr_q;  s3_lfsr_d = s2_lfsr_q;
      s2_any_d  = |s1_en_q;   s3_any_d  = s2_any_q;
      if (s3_any_q)
        acc = acc + SUM_W'($signed({1'b0, s3_lfsr_q[1:0]}) - $signed({1'b0, s3_lfsr_q[3:2]}));
`endif
      src_valid_d = s3_valid_q;
      if (acc > SAT_HI) begin
        src_data_d  = SAT_HI[OUT_W-1:0];
        src_error_d = 2'b01;
      end else if (acc < SAT_LO) begin
        src_data_d  = SAT_LO[OUT_W-1:0];
        src_error_d = 2'b01;
      end else begin
        src_data_d  = acc[OUT_W-1:0];
        src_error_d = 2'b00;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        phase_q[c] <= '0; inc_q[c] <= '0; amp_q[c] <= '0; mode_q[c] <= '0;
        s1_phase_q[c] <= '0; s1_amp_q[c] <= '0; s1_mode_q[c] <= '0;
        s2_wave_q[c] <= '0; s2_amp_q[c] <= '0; s3_scaled_q[c] <= '0;
      end
      en_q <= '0; lfsr_q <= 16'hACE1;
      s1_en_q <= '0; s1_lfsr_q <= '0; s1_valid_q <= 1'b0;
      s2_en_q <= '0; s2_valid_q <= 1'b0; s3_valid_q <= 1'b0;
      src_valid_q <= 1'b0; src_data_q <= '0; src_error_q <= '0;
`ifdef MULTI_TONE_GEN_DITHER_EN
      s2_lfsr_q <= '0; s3_lfsr_q <= '0; s2_any_q <= 1'b0; s3_any_q <= 1'b0;
`endif
    end else begin
      phase_q <= phase_d; inc_q <= inc_d; amp_q <= amp_d; mode_q <= mode_d;
      en_q <= en_d; lfsr_q <= lfsr_d;
      s1_phase_q <= s1_phase_d; s1_amp_q <= s1_amp_d; s1_mode_q <= s1_mode_d;
      s1_en_q <= s1_en_d; s1_lfsr_q <= s1_lfsr_d; s1_valid_q <= s1_valid_d;
      s2_wave_q <= s2_wave_d; s2_amp_q <= s2_amp_d; s2_en_q <= s2_en_d; s2_valid_q <= s2_valid_d;
      s3_scaled_q <= s3_scaled_d; s3_valid_q <= s3_valid_d;
      src_valid_q <= src_valid_d; src_data_q <= src_data_d; src_error_q <= src_error_d;
`ifdef MULTI_TONE_GEN_DITHER_EN
      s2_lfsr_q <= s2_lfsr_d; s3_lfsr_q <= s3_lfsr_d; s2_any_q <= s2_any_d; s3_any_q <= s3_any_d;
`endif
    end
  end

  assign src_valid = src_valid_q;
  assign src_data  = src_data_q;
  assign src_error = src_error_q;
endmodule

// File: tb/tb_multi_tone_gen.sv
// tb/tb_multi_tone_gen.sv - self-checking bench for multi_tone_gen
// Directed vector table, backpressure sequences and randomized traffic against a sample-level model.
module tb_multi_tone_gen;
  localparam int CH  = 2;
  localparam int PW  = 32;
  localparam int OW  = 16;
  localparam int AW  = 10;
  localparam int MFS = (1 << (OW - 1)) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_wr = 1'b0;
  logic [0:0]    cfg_chan = '0;
  logic [PW-1:0] cfg_phase_inc = '0;
  logic [8:0]    cfg_amp = '0;
  logic [1:0]    cfg_mode = '0;
  logic          cfg_en = 1'b0;
  logic          src_ready = 1'b0;
  logic          src_valid;
  logic [OW-1:0] src_data;
  logic [1:0]    src_error;

  multi_tone_gen #(.CHANNELS(CH), .PHASE_W(PW), .OUT_W(OW), .LUT_AW(AW)) dut (
    .clock(clock), .reset(reset), .cfg_wr(cfg_wr), .cfg_chan(cfg_chan),
    .cfg_phase_inc(cfg_phase_inc), .cfg_amp(cfg_amp), .cfg_mode(cfg_mode), .cfg_en(cfg_en),
    .src_ready(src_ready), .src_valid(src_valid), .src_data(src_data), .src_error(src_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sample-level reference: one sample per accepted cycle, emitted four accepted cycles later
  typedef struct { int d; int e; } samp_t;
  longint unsigned m_phase [CH];
  longint unsigned m_inc [CH];
  int              m_amp [CH];
  int              m_mode [CH];
  bit              m_en [CH];
  logic [15:0]     m_lfsr;
  samp_t           m_q [$];
  bit              m_valid;
  int              m_data;
  int              m_err;

  function automatic int sine_val(input longint unsigned ph);
    longint unsigned q, a, k;
    real r;
    int mag;
    q = ph >> (PW - 2);
    a = (ph >> (PW - 2 - AW)) % (64'd1 << AW);
    k = (q % 2 == 1) ? (64'd1 << AW) - a : a;
    r = MFS * $sin(3.14159265358979323846 / 2.0 * real'(k) / real'(1 << AW));
    mag = $rtoi(r + 0.5);
    return (q >= 2) ? -mag : mag;
  endfunction

  function automatic int wave_of(input int c);
    int s;
    case (m_mode[c])
      0: return sine_val(m_phase[c]);
      1: return (m_phase[c] >> (PW - 1)) != 0 ? -MFS : MFS;
      2: begin
        s = int'(m_phase[c] >> (PW - OW));
        return (s >= (1 << (OW - 1))) ? s - (1 << OW) : s;
      end
      default: return int'($signed(m_lfsr));
    endcase
  endfunction

  function automatic samp_t model_sample();
    samp_t r;
    int acc;
    acc = 0;
    for (int c = 0; c < CH; c++)
      if (m_en[c]) acc += (wave_of(c) * m_amp[c]) >>> 8;
`ifdef MULTI_TONE_GEN_DITHER_EN
    if (m_en[0] || m_en[1]) acc += int'(m_lfsr[1:0]) - int'(m_lfsr[3:2]);
`endif
    r.e = 0;
    if (acc > MFS) begin acc = MFS; r.e = 1; end
    else if (acc < -MFS - 1) begin acc = -MFS - 1; r.e = 1; end
    r.d = acc;
    return r;
  endfunction

  always @(posedge clock) begin
    samp_t s;
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        m_phase[c] = 0; m_inc[c] = 0; m_amp[c] = 0; m_mode[c] = 0; m_en[c] = 0;
      end
      m_lfsr = 16'hACE1;
      m_q.delete();
      m_valid = 0; m_data = 0; m_err = 0;
    end else begin
      if (src_ready || !m_valid) begin
        m_q.push_back(model_sample());
        if (m_q.size() == 4) begin
          s = m_q.pop_front();
          m_valid = 1; m_data = s.d; m_err = s.e;
        end
        for (int c = 0; c < CH; c++) m_phase[c] = (m_phase[c] + m_inc[c]) % (64'd1 << PW);
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      end
      if (cfg_wr && int'(cfg_chan) < CH) begin
        m_phase[cfg_chan] = 0;
        m_inc[cfg_chan]   = cfg_phase_inc;
        m_amp[cfg_chan]   = (cfg_amp > 256) ? 256 : int'(cfg_amp);
        m_mode[cfg_chan]  = int'(cfg_mode);
        m_en[cfg_chan]    = cfg_en;
      end
    end
  end

  always @(negedge clock) begin
    check("model_valid", src_valid, m_valid);
    check("model_data", $signed(src_data), m_data);
    check("model_error", src_error, m_err);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1; src_ready = 1; cfg_wr = 0;
    tick(3);
    reset = 0;
  endtask

  task automatic write_cfg(input int ch, input longint inc, input int amp, input int mode, input bit en);
    cfg_wr = 1; cfg_chan = 1'(ch); cfg_phase_inc = PW'(inc);
    cfg_amp = 9'(amp); cfg_mode = 2'(mode); cfg_en = en;
    tick(1);
    cfg_wr = 0;
  endtask

  // Reset, then configure both channels while stalled so their phases start together
  task automatic setup(input int m0, input int a0, input longint i0, input int m1, input int a1, input bit e1);
    do_reset();
    tick(4);
    src_ready = 0;
    write_cfg(0, i0, a0, m0, 1);
    write_cfg(1, i0, a1, m1, e1);
    src_ready = 1;
    tick(3);
  endtask

  function automatic int saw_exp(input int k);
    return ((k * 4096 + 32768) % 65536) - 32768;
  endfunction

  typedef struct {
    string name; int mode; bit en1; int amp;
    int e0; int e1; int e2; int e3; int err;
  } vec_t;

  initial begin
    vec_t vecs [5];
    int e [4];
    int nz, diff, base;

    vecs[0] = '{"square_ch0",     1, 0, 256, 32767, 32767, -32767, -32767, 0};
    vecs[1] = '{"sine_amp256",    0, 0, 256, 0, 32767, 0, -32767, 0};
    vecs[2] = '{"sine_amp128",    0, 0, 128, 0, 16383, 0, -16384, 0};
    vecs[3] = '{"square_x2_clip", 1, 1, 256, 32767, 32767, -32768, -32768, 1};
    vecs[4] = '{"square_x2_half", 1, 1, 128, 32766, 32766, -32768, -32768, 0};

    reset = 1; src_ready = 1;
    tick(3);
    reset = 0;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      check($sformatf("reset_valid_edge%0d", k), src_valid, (k == 4) ? 1 : 0);
      check($sformatf("reset_data_edge%0d", k), $signed(src_data), 0);
    end
    check("reset_error", src_error, 0);
    tick(3);
    check("idle_data", $signed(src_data), 0);

`ifndef MULTI_TONE_GEN_DITHER_EN
    foreach (vecs[v]) begin
      setup(vecs[v].mode, vecs[v].amp, 64'd1 << 30, vecs[v].mode, vecs[v].amp, vecs[v].en1);
      e = '{vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].e3};
      for (int k = 0; k < 8; k++) begin
        tick(1);
        check($sformatf("%s_data%0d", vecs[v].name, k), $signed(src_data), e[k % 4]);
        check($sformatf("%s_err%0d", vecs[v].name, k), src_error, vecs[v].err);
      end
    end

    setup(2, 256, 64'd1 << 28, 0, 0, 0);
    tick(7);
    check("saw_before_stall", $signed(src_data), saw_exp(6));
    src_ready = 0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("saw_stall_frozen", $signed(src_data), saw_exp(6));
      check("saw_stall_valid", src_valid, 1);
    end
    src_ready = 1;
    tick(1);
    check("saw_after_stall", $signed(src_data), saw_exp(7));
    src_ready = 0;
    tick(1);
    write_cfg(0, 64'd1 << 28, 256, 2, 1);
    tick(2);
    check("saw_stall2_frozen", $signed(src_data), saw_exp(7));
    src_ready = 1;
    for (int k = 8; k <= 10; k++) begin
      tick(1);
      check("saw_inflight", $signed(src_data), saw_exp(k));
    end
    tick(1);
    check("saw_restart_phase0", $signed(src_data), 0);
    tick(1);
    check("saw_restart_next", $signed(src_data), 4096);
`endif

`ifdef MULTI_TONE_GEN_DITHER_EN
    setup(1, 256, 64'd1 << 30, 0, 0, 0);
    nz = 0;
    for (int k = 0; k < 1000; k++) begin
      tick(1);
      base = (k % 4 < 2) ? 32767 : -32767;
      diff = int'($signed(src_data)) - base;
      if (diff != 0) nz++;
      check("dither_range", (diff >= -3 && diff <= 3) ? 1 : 0, 1);
    end
    check("dither_active", (nz > 0) ? 1 : 0, 1);
`endif

    do_reset();
    for (int k = 0; k < 1500; k++) begin
      src_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 199) == 0);
      cfg_wr = ($urandom_range(0, 19) == 0);
      cfg_chan = 1'($urandom_range(0, 1));
      cfg_phase_inc = PW'($urandom);
      cfg_amp = 9'($urandom_range(0, 511));
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_en = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    cfg_wr = 0; reset = 0; src_ready = 1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
